// File: rtl/call_stack_unit_if.sv
// Handshake bundle between the CPU control path and the return-address stack.
// master = CPU side (drives strobes and data), slave = stack.
interface call_stack_unit_if #(
  parameter int AW = 10,
  parameter int FW = 2,
  parameter int CW = 5
);
  logic          push;
  logic          pop;
  logic          flush;
  logic          clr_err;
  logic [AW-1:0] ret_addr;
  logic [FW-1:0] flags_in;
  logic [AW-1:0] top_addr;
  logic [FW-1:0] top_flags;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          unf;

  modport master (
    output push, pop, flush, clr_err, ret_addr, flags_in,
    input  top_addr, top_flags, count, empty, full, ovf, unf
  );

  modport slave (
    input  push, pop, flush, clr_err, ret_addr, flags_in,
    output top_addr, top_flags, count, empty, full, ovf, unf
  );
endinterface

// File: rtl/call_stack_unit.sv
// Return-address stack with optional saved flags, sticky over/underflow errors,
// same-cycle replace and synchronous flush. The top entry is read combinationally.
module call_stack_unit #(
  parameter int AW         = 10,
  parameter int DEPTH      = 16,
  parameter int FW         = 2,
  parameter int SAVE_FLAGS = 1,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  call_stack_unit_if.slave  bus
);
  localparam int            IW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0] sp;
  logic [CW-1:0] sp_next;
  logic [CW-1:0] sp_m1;
  logic          ovf;
  logic          unf;
  logic          ovf_ev;
  logic          unf_ev;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          empty;
  logic          full;
  logic [AW-1:0] addr_mem [DEPTH];

  assign empty   = (sp == '0);
  assign full    = (sp == FULL_CNT);
  assign sp_m1   = sp - CW'(1);
  assign top_idx = sp_m1[IW-1:0];

  always_comb begin
    sp_next = sp;
    wr_en   = 1'b0;
    wr_idx  = sp[IW-1:0];
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    if (bus.flush) begin
      sp_next = '0;
    end else if (bus.push && !bus.pop) begin
      if (!full) begin
        wr_en   = 1'b1;
        sp_next = sp + CW'(1);
      end else begin
        ovf_ev = 1'b1;
      end
    end else if (bus.pop && !bus.push) begin
      if (!empty) sp_next = sp_m1;
      else        unf_ev  = 1'b1;
    end else if (bus.push && bus.pop) begin
      // Replace overwrites the top in place; on an empty stack it degrades to a push.
      wr_en = 1'b1;
      if (!empty) begin
        wr_idx = top_idx;
      end else begin
        sp_next = CW'(1);
        unf_ev  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      sp  <= sp_next;
      ovf <= ovf_ev | (ovf & ~bus.clr_err);
      unf <= unf_ev | (unf & ~bus.clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) addr_mem[wr_idx] <= bus.ret_addr;
  end

  generate
    if (SAVE_FLAGS != 0) begin : g_flags
      logic [FW-1:0] flag_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_en) flag_mem[wr_idx] <= bus.flags_in;
      end
      assign bus.top_flags = empty ? '0 : flag_mem[top_idx];
    end else begin : g_no_flags
      assign bus.top_flags = '0;
    end
  endgenerate

  assign bus.top_addr = empty ? '0 : addr_mem[top_idx];
  assign bus.count    = sp;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.ovf      = ovf;
  assign bus.unf      = unf;
endmodule

// File: tb/tb_call_stack_unit.sv
// Bench for call_stack_unit: queue-based model checked every cycle on a DEPTH=4
// instance, plus literal expectations on it and on a DEPTH=5 no-flags instance.
module tb_call_stack_unit;
  localparam int A_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  call_stack_unit_if #(.AW(10), .FW(2), .CW(3)) ifa ();
  call_stack_unit_if #(.AW(10), .FW(2), .CW(3)) ifb ();

  call_stack_unit #(.AW(10), .DEPTH(4), .FW(2), .SAVE_FLAGS(1)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa)
  );
  call_stack_unit #(.AW(10), .DEPTH(5), .FW(2), .SAVE_FLAGS(0)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model of dut_a: a queue of entries, top at the back.
  logic [9:0] m_addr  [$];
  logic [1:0] m_flags [$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit ev_o, ev_u;
  bit model_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_addr.delete();
      m_flags.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      ev_o = 1'b0;
      ev_u = 1'b0;
      if (ifa.flush) begin
        m_addr.delete();
        m_flags.delete();
      end else if (ifa.push && !ifa.pop) begin
        if (m_addr.size() < A_DEPTH) begin
          m_addr.push_back(ifa.ret_addr);
          m_flags.push_back(ifa.flags_in);
        end else ev_o = 1'b1;
      end else if (ifa.pop && !ifa.push) begin
        if (m_addr.size() > 0) begin
          void'(m_addr.pop_back());
          void'(m_flags.pop_back());
        end else ev_u = 1'b1;
      end else if (ifa.push && ifa.pop) begin
        if (m_addr.size() > 0) begin
          m_addr[m_addr.size()-1]   = ifa.ret_addr;
          m_flags[m_flags.size()-1] = ifa.flags_in;
        end else begin
          m_addr.push_back(ifa.ret_addr);
          m_flags.push_back(ifa.flags_in);
          ev_u = 1'b1;
        end
      end
      m_ovf = ev_o || (m_ovf && !ifa.clr_err);
      m_unf = ev_u || (m_unf && !ifa.clr_err);
    end
  end

  function automatic logic [31:0] m_top_addr();
    return (m_addr.size() > 0) ? 32'(m_addr[m_addr.size()-1]) : 32'd0;
  endfunction

  function automatic logic [31:0] m_top_flags();
    return (m_flags.size() > 0) ? 32'(m_flags[m_flags.size()-1]) : 32'd0;
  endfunction

  // Literal expectation mailbox, consumed by the compare process.
  bit    lit_en = 1'b0;
  int    ex_sel;
  string ex_name;
  int    ex_cnt, ex_top, ex_fl;
  bit    ex_e, ex_f, ex_o, ex_u;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (model_en) begin
      chk("model_count", 32'(ifa.count), 32'(m_addr.size()));
      chk("model_top_addr", 32'(ifa.top_addr), m_top_addr());
      chk("model_top_flags", 32'(ifa.top_flags), m_top_flags());
      chk("model_empty", 32'(ifa.empty), 32'(m_addr.size() == 0));
      chk("model_full", 32'(ifa.full), 32'(m_addr.size() == A_DEPTH));
      chk("model_ovf", 32'(ifa.ovf), 32'(m_ovf));
      chk("model_unf", 32'(ifa.unf), 32'(m_unf));
    end
    if (lit_en) begin
      if (ex_sel == 0) begin
        chk({ex_name, "_count"}, 32'(ifa.count), 32'(ex_cnt));
        chk({ex_name, "_top"}, 32'(ifa.top_addr), 32'(ex_top));
        chk({ex_name, "_flags"}, 32'(ifa.top_flags), 32'(ex_fl));
        chk({ex_name, "_empty"}, 32'(ifa.empty), 32'(ex_e));
        chk({ex_name, "_full"}, 32'(ifa.full), 32'(ex_f));
        chk({ex_name, "_ovf"}, 32'(ifa.ovf), 32'(ex_o));
        chk({ex_name, "_unf"}, 32'(ifa.unf), 32'(ex_u));
      end else begin
        chk({ex_name, "_count"}, 32'(ifb.count), 32'(ex_cnt));
        chk({ex_name, "_top"}, 32'(ifb.top_addr), 32'(ex_top));
        chk({ex_name, "_flags"}, 32'(ifb.top_flags), 32'(ex_fl));
        chk({ex_name, "_empty"}, 32'(ifb.empty), 32'(ex_e));
        chk({ex_name, "_full"}, 32'(ifb.full), 32'(ex_f));
        chk({ex_name, "_ovf"}, 32'(ifb.ovf), 32'(ex_o));
        chk({ex_name, "_unf"}, 32'(ifb.unf), 32'(ex_u));
      end
    end
  end

  // Apply one set of strobes for exactly one rising edge, then return to idle.
  task automatic op_a(input bit p, input bit po, input bit f, input bit c,
                      input int addr, input int fl);
    ifa.push = p; ifa.pop = po; ifa.flush = f; ifa.clr_err = c;
    ifa.ret_addr = 10'(addr); ifa.flags_in = 2'(fl);
    @(posedge clk); #1;
    ifa.push = 0; ifa.pop = 0; ifa.flush = 0; ifa.clr_err = 0;
  endtask

  task automatic op_b(input bit p, input bit po, input int addr, input int fl);
    ifb.push = p; ifb.pop = po; ifb.ret_addr = 10'(addr); ifb.flags_in = 2'(fl);
    @(posedge clk); #1;
    ifb.push = 0; ifb.pop = 0;
  endtask

  task automatic want(input int sel, input string nm, input int cnt, input int top,
                      input int fl, input bit e, input bit f, input bit o, input bit u);
    ex_sel = sel; ex_name = nm; ex_cnt = cnt; ex_top = top; ex_fl = fl;
    ex_e = e; ex_f = f; ex_o = o; ex_u = u;
    lit_en = 1'b1;
    @(posedge clk); #1;
    lit_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifa.push = 0; ifa.pop = 0; ifa.flush = 0; ifa.clr_err = 0; ifa.ret_addr = 0; ifa.flags_in = 0;
    ifb.push = 0; ifb.pop = 0; ifb.flush = 0; ifb.clr_err = 0; ifb.ret_addr = 0; ifb.flags_in = 0;
    #1 rst = 1'b1;
    model_en = 1'b1;
    want(0, "reset", 0, 'h000, 0, 1, 0, 0, 0);
    rst = 1'b0;

    // Basic push / pop
    op_a(1, 0, 0, 0, 'h011, 1);
    op_a(1, 0, 0, 0, 'h022, 2);
    op_a(1, 0, 0, 0, 'h033, 3);
    want(0, "push3", 3, 'h033, 3, 0, 0, 0, 0);
    op_a(0, 1, 0, 0, 0, 0);
    want(0, "pop1", 2, 'h022, 2, 0, 0, 0, 0);
    op_a(0, 1, 0, 0, 0, 0);
    want(0, "pop2", 1, 'h011, 1, 0, 0, 0, 0);
    op_a(0, 1, 0, 0, 0, 0);
    want(0, "pop3", 0, 'h000, 0, 1, 0, 0, 0);

    // Fill and overflow
    for (int i = 0; i < 4; i++) op_a(1, 0, 0, 0, 'h100 + i, i);
    want(0, "fill", 4, 'h103, 3, 0, 1, 0, 0);
    op_a(1, 0, 0, 0, 'h3FF, 0);
    want(0, "ovf_push", 4, 'h103, 3, 0, 1, 1, 0);
    op_a(0, 1, 0, 0, 0, 0);
    want(0, "pop_after_ovf", 3, 'h102, 2, 0, 0, 1, 0);
    op_a(0, 0, 0, 1, 0, 0);
    op_a(0, 0, 1, 0, 0, 0);
    want(0, "clr_flush", 0, 'h000, 0, 1, 0, 0, 0);

    // Underflow and sticky clear priority
    op_a(0, 1, 0, 0, 0, 0);
    want(0, "unf_pop", 0, 'h000, 0, 1, 0, 0, 1);
    op_a(0, 0, 0, 1, 0, 0);
    want(0, "unf_clr", 0, 'h000, 0, 1, 0, 0, 0);
    op_a(0, 1, 0, 1, 0, 0);
    want(0, "unf_clr_vs_event", 0, 'h000, 0, 1, 0, 0, 1);
    op_a(0, 0, 0, 1, 0, 0);

    // Replace
    op_a(1, 0, 0, 0, 'h010, 0);
    op_a(1, 0, 0, 0, 'h020, 1);
    op_a(1, 1, 0, 0, 'h2AA, 2);
    want(0, "replace", 2, 'h2AA, 2, 0, 0, 0, 0);
    op_a(0, 1, 0, 0, 0, 0);
    want(0, "pop_after_replace", 1, 'h010, 0, 0, 0, 0, 0);
    op_a(1, 0, 0, 0, 'h030, 1);
    op_a(1, 0, 0, 0, 'h040, 2);
    op_a(1, 0, 0, 0, 'h050, 3);
    op_a(1, 1, 0, 0, 'h1BB, 3);
    want(0, "replace_full", 4, 'h1BB, 3, 0, 1, 0, 0);
    op_a(0, 0, 1, 0, 0, 0);
    op_a(1, 1, 0, 0, 'h055, 1);
    want(0, "replace_empty", 1, 'h055, 1, 0, 0, 0, 1);
    op_a(0, 0, 1, 1, 0, 0);

    // Flush beats push
    op_a(1, 0, 0, 0, 'h070, 0);
    op_a(1, 0, 0, 0, 'h071, 1);
    op_a(1, 0, 0, 0, 'h072, 2);
    op_a(1, 0, 1, 0, 'h077, 3);
    want(0, "flush_push", 0, 'h000, 0, 1, 0, 0, 0);
    op_a(0, 1, 0, 0, 0, 0);
    want(0, "pop_after_flush", 0, 'h000, 0, 1, 0, 0, 1);

    // Async reset between edges with both errors set
    for (int i = 0; i < 5; i++) op_a(1, 0, 0, 0, 'h0C0 + i, i);
    want(0, "pre_reset", 4, 'h0C3, 3, 0, 1, 1, 1);
    #2 rst = 1'b1;
    want(0, "async_reset", 0, 'h000, 0, 1, 0, 0, 0);
    rst = 1'b0;
    op_a(1, 0, 0, 0, 'h0AB, 2);
    want(0, "post_reset_push", 1, 'h0AB, 2, 0, 0, 0, 0);

    // No-flags instance, DEPTH=5
    want(1, "b_reset", 0, 'h000, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      op_b(1, 0, 'h200 + i, 3);
      want(1, "b_fill", i + 1, 'h200 + i, 0, 0, (i == 4), 0, 0);
    end
    op_b(1, 0, 'h2FF, 3);
    want(1, "b_ovf", 5, 'h204, 0, 0, 1, 1, 0);
    op_b(0, 1, 0, 0);
    want(1, "b_pop", 4, 'h203, 0, 0, 0, 1, 0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/call_stack_unit.md
Name: call_stack_unit

Overview:
- Parametrised return-address stack for the single-cycle CPU. Replaces the fixed subroutine stack driven by the control unit's push/pop strobes.
- Saves the return PC on push. Optionally also saves the ALU flags (z, carry), so interrupt-style entries can restore status.
- Adds capabilities the previous stack lacked: depth and width parameters, full/empty/count status, sticky overflow/underflow errors, same-cycle replace (push+pop), and synchronous flush.
- Sits in the datapath between the PC incrementer and the PC next-value mux.

Parameters:
- AW, 10, width in bits of a stored return address.
- DEPTH, 16, number of entries; any value >= 2.
- FW, 2, width of the saved flag field (bit0 = z, bit1 = carry).
- SAVE_FLAGS, 1, 1 = store flags_in with each entry; 0 = flag storage removed and top_flags tied to 0.
- CW, $clog2(DEPTH+1), width of the count output (derived).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  store {flags_in, ret_addr} on top of stack this edge.
- pop  input  1  remove top entry this edge.
- flush  input  1  synchronous clear of the stack pointer.
- clr_err  input  1  synchronous clear of the sticky error bits.
- ret_addr  input  AW  return address to save (PC+1 from the datapath).
- flags_in  input  FW  flags to save with the entry.
- top_addr  output  AW  address of the current top entry (combinational).
- top_flags  output  FW  flags of the current top entry (combinational).
- count  output  CW  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- ovf  output  1  sticky overflow error.
- unf  output  1  sticky underflow error.

Behaviour:
- Reset (asynchronous, active-high):
  - sp=0, ovf=0, unf=0.
  - Resulting outputs: count=0, empty=1, full=0, top_addr=0, top_flags=0.
  - Entry storage is not reset.
- Read path:
  - top_addr/top_flags = mem[sp-1] when sp>0, else all zeros.
  - Purely combinational, so a return instruction uses the value in the same cycle it asserts pop (zero-latency read).
- Write path: all state updates on the rising clk edge, in priority order flush > push/pop.
- flush=1: sp<=0. push/pop are ignored that cycle. Error bits are unaffected unless clr_err is also asserted.
- push=1, pop=0:
  - Not full: mem[sp]<={flags_in, ret_addr}, sp<=sp+1.
  - Full: no write, sp unchanged, ovf<=1.
- pop=1, push=0:
  - Not empty: sp<=sp-1.
  - Empty: sp stays 0, unf<=1.
- push=1, pop=1 (replace / tail-call):
  - Not empty: mem[sp-1]<=new entry, sp unchanged. Allowed when full and never sets ovf.
  - Empty: acts as push only (mem[0] written, sp<=1), and unf<=1.
- Sticky errors:
  - ovf and unf hold at 1 until clr_err or reset.
  - If clr_err coincides with a new error event in the same cycle, the new event wins and the bit ends at 1.
- Error behaviour on the CPU side: an overflowing push discards the entry, so a later return goes to the older entry. An underflowing pop yields top_addr=0, i.e. the reset vector.
- Status outputs: count = sp. empty and full are decoded from sp, not registered separately, so they are consistent with count every cycle.
- SAVE_FLAGS=0: flags_in is ignored, the flag storage is not synthesised, and top_flags=0.
- Reset asserted mid-sequence: immediate return to the reset state regardless of clk. The first edge after reset deassertion behaves as for an empty stack.

Test Plan (AW=10, DEPTH=4, FW=2, SAVE_FLAGS=1 unless noted):
- Reset, then push 0x011/flags 2'b01, 0x022/2'b10, 0x033/2'b11 -> count=3, top_addr=0x033, top_flags=2'b11. Pop ×3 -> top_addr reads 0x022, 0x011, then 0x000 with empty=1, unf=0.
- Push 4 entries (0x100..0x103) -> full=1. Push 0x3FF -> ovf=1, count=4, top_addr=0x103. Pop once -> top_addr=0x102.
- From empty, pop -> unf=1, count=0, top_addr=0. clr_err -> unf=0. Assert clr_err together with another empty pop -> unf stays 1.
- Stack holding 0x010, 0x020: push+pop with ret_addr=0x2AA -> count=2, top_addr=0x2AA. Pop -> top_addr=0x010. Repeat the replace when full -> ovf stays 0. Push+pop on empty with 0x055 -> count=1, top_addr=0x055, unf=1.
- 3 entries present: assert flush together with push 0x077 -> count=0, empty=1, no write (a following pop flags unf). Raise async reset between clock edges after pushes -> count=0, ovf=unf=0 immediately, without waiting for a clk edge.
- SAVE_FLAGS=0, DEPTH=5: push 5 entries with flags_in=2'b11 -> top_flags=0 throughout, full asserts only at count=5 (CW=3).
